// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Pure definitions: no latency or flow-control behaviour of its own.
package arb_pkg;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping 7 -> 0.
// Zero latency; no backpressure, result is a pure function of req and ptr.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] src;
   logic [IDX_W-1:0] enc;

   always_comb begin
      rot = '0;
      src = '0;
      for (int i = 0; i < N_REQ; i++) begin
         src    = IDX_W'(i) + ptr;
         rot[i] = req[src];
      end
   end

   // Scan downward so the lowest set bit of the rotated vector wins.
   always_comb begin
      enc = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) enc = IDX_W'(i);
      end
   end

   always_comb begin
      any    = |req;
      idx    = enc + ptr;
      onehot = N_REQ'(1) << idx;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant held while the owner requests,
// one-cycle grant latency from idle, same-edge handover on release, forced rotation at MAX_HOLD.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   state_t            state_q,    state_d;
   logic [IDX_W-1:0]  ptr_q,      ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0]  gnt_q,      gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q,  gnt_idx_d;
   logic              preempt_q,  preempt_d;

   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic [N_REQ-1:0]  pick_onehot;
   logic              owner_req;
   logic              others_pending;
   logic              hold_expired;

   rr_pick8 u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         preempt_q  <= preempt_d;
      end
   end

   always_comb begin
      owner_req      = |(req & gnt_q);
      others_pending = |(req & ~gnt_q);
      hold_expired   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      preempt_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = GRANT;
               gnt_d      = pick_onehot;
               gnt_idx_d  = pick_idx;
               ptr_d      = pick_idx + IDX_W'(1);
               hold_cnt_d = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               if (pick_any) begin
                  gnt_d      = pick_onehot;
                  gnt_idx_d  = pick_idx;
                  ptr_d      = pick_idx + IDX_W'(1);
                  hold_cnt_d = '0;
               end else begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  gnt_idx_d  = '0;
                  hold_cnt_d = '0;
               end
            end else if (hold_expired) begin
               // ptr already points past the owner, so the owner is searched last.
               if (others_pending) begin
                  gnt_d      = pick_onehot;
                  gnt_idx_d  = pick_idx;
                  ptr_d      = pick_idx + IDX_W'(1);
                  preempt_d  = 1'b1;
               end
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt       = gnt_q;
      gnt_idx   = gnt_idx_q;
      gnt_valid = (state_q == GRANT);
      preempt   = preempt_q;
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8 with MAX_HOLD=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic owner(input string tag, input int k, input logic exp_pre);
      check({tag, " gnt"}, 32'(gnt), 32'(8'h01 << k));
      check({tag, " idx"}, 32'(gnt_idx), 32'(k));
      check({tag, " vld"}, 32'(gnt_valid), 32'd1);
      check({tag, " pre"}, 32'(preempt), 32'(exp_pre));
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = 8'hFF;

      // Reset held two cycles with everyone requesting.
      tick(); tick();
      check("rst gnt", 32'(gnt), 32'h0);
      check("rst vld", 32'(gnt_valid), 32'd0);
      check("rst pre", 32'(preempt), 32'd0);
      rst = 1'b0;
      tick();
      owner("first", 0, 1'b0);

      // Each owner holds 3 cycles, drops for one edge, handover has no idle bubble.
      for (int k = 0; k < 8; k++) begin
         owner("rot", k, 1'b0);
         tick(); tick();
         req[k] = 1'b0;
         tick();
         req = 8'hFF;
      end
      owner("rot wrap", 0, 1'b0);

      // Move ptr to 6 by granting 5, then check wrap and skip.
      req = 8'h20;
      tick();
      owner("to5", 5, 1'b0);
      req = 8'b0000_0101;
      tick();
      owner("wrap", 0, 1'b0);
      req = 8'b0000_0100;
      tick();
      owner("skip", 2, 1'b0);

      // Preemption between 3 and 5 with MAX_HOLD=4.
      req = 8'h08;
      tick();
      req = 8'h28;
      for (int i = 0; i < 4; i++) begin
         owner("hold3", 3, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         owner("hold5", 5, (i == 0));
         tick();
      end
      owner("back3", 3, 1'b1);
      tick();
      owner("back3b", 3, 1'b0);

      // Lone holder never preempted.
      req = 8'h04;
      for (int i = 0; i < 20; i++) begin
         tick();
         owner("lone", 2, 1'b0);
      end

      // Mid-grant reset clears grant and resets the search pointer.
      req = 8'h10;
      tick();
      owner("own4", 4, 1'b0);
      rst = 1'b1;
      tick();
      check("mrst gnt", 32'(gnt), 32'h0);
      check("mrst vld", 32'(gnt_valid), 32'd0);
      check("mrst idx", 32'(gnt_idx), 32'd0);
      rst = 1'b0;
      req = 8'h82;
      tick();
      owner("post rst", 1, 1'b0);

      req = 8'h00;
      tick(); tick();
      check("idle gnt", 32'(gnt), 32'h0);
      check("idle vld", 32'(gnt_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
